// File: rtl/cr_tlvp_usr_arb_pkg.sv
// Shared cr_structs types for the cr_tlvp user-path arbiter: TLV bus word,
// arbiter state encoding and the engine-count ceiling.
package cr_structs;

  localparam int unsigned CR_TLVP_USR_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic        sot;
    logic        eot;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } tlvp_if_bus_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cr_tlvp_usr_arb_if.sv
// Engine-FIFO side and cr_tlvp user-outbound side of the arbiter, grouped.
// master = environment (engines + cr_tlvp), slave = arbiter.
interface cr_tlvp_usr_arb_if import cr_structs::*; #(
  parameter int unsigned N_REQ = 4
);

  logic         [N_REQ-1:0] req_empty;
  tlvp_if_bus_t [N_REQ-1:0] req_tlv;
  logic         [N_REQ-1:0] req_rd;
  logic                     usr_ob_afull;
  logic                     usr_ob_wr;
  tlvp_if_bus_t             usr_ob_tlv;

  modport master (
    output req_empty,
    output req_tlv,
    output usr_ob_afull,
    input  req_rd,
    input  usr_ob_wr,
    input  usr_ob_tlv
  );

  modport slave (
    input  req_empty,
    input  req_tlv,
    input  usr_ob_afull,
    output req_rd,
    output usr_ob_wr,
    output usr_ob_tlv
  );

endinterface

// File: rtl/cr_tlvp_usr_arb_rr_pick.sv
// cr_tlvp_rr_pick: combinational round-robin pick of the first set request
// bit after index `last`, wrapping modulo N_REQ.
module cr_tlvp_rr_pick import cr_structs::*; #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last,
  output logic [2:0]       gnt,
  output logic             vld
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    // Offsets 1..N_REQ so that `last` itself is considered only after all others.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = IDX_W'((32'(last) + i) % N_REQ);
      if (!vld && req[idx]) begin
        gnt = 3'(idx);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_tlvp_usr_arb.sv
// cr_tlvp_usr_arb: round-robin arbiter merging N_REQ engine TLV FIFOs into the
// cr_tlvp user outbound FIFO, one whole TLV per grant. Optional stall
// watchdog enabled by defining CR_TLVP_USR_ARB_WDOG_EN.
module cr_tlvp_usr_arb import cr_structs::*; #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  cr_tlvp_usr_arb_if.slave    bus,
  output logic [2:0]          arb_gnt_id,
  output logic                arb_busy,
  output logic                arb_error
);

  localparam int unsigned IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [2:0]  LAST_RST = 3'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [2:0]       last_q, last_d;
  logic             wr_q, wr_d;
  tlvp_if_bus_t     tlv_q, tlv_d;

  logic [N_REQ-1:0] rd;
  logic             pop;
  logic [IDX_W-1:0] gidx;
  logic             gnt_empty;
  tlvp_if_bus_t     gnt_tlv;
  logic [2:0]       pick_gnt;
  logic             pick_vld;

  cr_tlvp_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req  (~bus.req_empty),
    .last (last_q),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  assign gidx      = gnt_q[IDX_W-1:0];
  assign gnt_empty = bus.req_empty[gidx];
  assign gnt_tlv   = bus.req_tlv[gidx];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rd      = '0;
    pop     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_gnt;
          last_d  = pick_gnt;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Grant is held through empty/afull stalls until the eot word is popped.
        if (!gnt_empty && !bus.usr_ob_afull) begin
          pop      = 1'b1;
          rd[gidx] = 1'b1;
          if (gnt_tlv.eot) begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    wr_d  = pop;
    tlv_d = pop ? gnt_tlv : tlv_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      wr_q    <= 1'b0;
      tlv_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      tlv_q   <= tlv_d;
    end
  end

  assign bus.req_rd     = rd;
  assign bus.usr_ob_wr  = wr_q;
  assign bus.usr_ob_tlv = tlv_q;
  assign arb_gnt_id     = gnt_q;
  assign arb_busy       = (state_q == ARB_BUSY);

`ifdef CR_TLVP_USR_ARB_WDOG_EN
  localparam int unsigned     WD_W   = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (pop) begin
      wd_cnt_d = '0;
    end else if (state_q == ARB_BUSY && gnt_empty && wd_cnt_q != WD_MAX) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    err_d = err_q | (wd_cnt_d == WD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign arb_error = err_q;
`else
  localparam bit CFG_OK = (N_REQ >= 2) && (N_REQ <= CR_TLVP_USR_ARB_MAX_REQ) &&
                          (WDOG_CYCLES >= 1);

  // Constant 0 for every legal parameter set.
  assign arb_error = ~CFG_OK;
`endif

endmodule

// File: tb/tb_cr_tlvp_usr_arb.sv
// Scoreboard bench for cr_tlvp_usr_arb: engine FIFO models feed the DUT,
// expected words are queued with the stimulus and checked on usr_ob_wr.
module tb_cr_tlvp_usr_arb;
  import cr_structs::*;

  localparam int unsigned N = 4;
`ifdef CR_TLVP_USR_ARB_WDOG_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] arb_gnt_id;
  logic       arb_busy;
  logic       arb_error;

  always #5 clk = ~clk;

  cr_tlvp_usr_arb_if #(.N_REQ(N)) bus ();

  cr_tlvp_usr_arb #(
    .N_REQ       (N),
    .WDOG_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .arb_gnt_id (arb_gnt_id),
    .arb_busy   (arb_busy),
    .arb_error  (arb_error)
  );

  tlvp_if_bus_t fq [N][$];
  tlvp_if_bus_t exp_q [$];
  int unsigned  wr_t [$];
  int unsigned  npop [N];
  int unsigned  cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic         prev_rd = 1'b0;
  logic [N-1:0] rd_cap = '0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic tlvp_if_bus_t mk_word(int unsigned eng, int unsigned id,
                                           int unsigned w, int unsigned total);
    tlvp_if_bus_t t;
    t.sot   = (w == 0);
    t.eot   = (w == total - 1);
    t.tuser = 8'(eng);
    t.tdata = {32'hA5A5_0000, 8'(eng), 16'(id), 8'(w)};
    return t;
  endfunction

  function automatic bit fifos_empty();
    for (int i = 0; i < N; i++) if (fq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      bus.req_empty[i] = (fq[i].size() == 0);
      bus.req_tlv[i]   = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic load(input int unsigned eng, input int unsigned id, input int unsigned first,
                      input int unsigned n, input int unsigned total);
    for (int unsigned w = first; w < first + n; w++) fq[eng].push_back(mk_word(eng, id, w, total));
    refresh();
  endtask

  task automatic expect_tlv(input int unsigned eng, input int unsigned id, input int unsigned first,
                            input int unsigned n, input int unsigned total);
    for (int unsigned w = first; w < first + n; w++) exp_q.push_back(mk_word(eng, id, w, total));
  endtask

  // Called right after a negedge; asserts reset and checks the async clear.
  task automatic reset_assert();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_wr",   bus.usr_ob_wr, 0);
    check("rst_tlv",  bus.usr_ob_tlv, 0);
    check("rst_gnt",  arb_gnt_id, 0);
    check("rst_busy", arb_busy, 0);
    check("rst_err",  arb_error, 0);
    check("rst_rd",   bus.req_rd, 0);
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      npop[i] = 0;
    end
    exp_q.delete();
    refresh();
  endtask

  task automatic reset_release();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("post_rst_rd", bus.req_rd, 0);
    check("post_rst_wr", bus.usr_ob_wr, 0);
  endtask

  task automatic wait_pops(input int unsigned eng, input int unsigned n, input string tag);
    for (int c = 0; c < 100 && npop[eng] < n; c++) @(negedge clk);
    check(tag, npop[eng], n);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned c = 0;
    while (c < 400 && !(exp_q.size() == 0 && fifos_empty() && !arb_busy)) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(tag, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Output monitor: write lag, grant-exclusive pops, scoreboard.
  initial begin
    tlvp_if_bus_t e;
    logic [N-1:0] one;
    one = 1;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        prev_rd = 1'b0;
        rd_cap  = '0;
      end else begin
        check("wr_lag", bus.usr_ob_wr, prev_rd);
        if (bus.req_rd != '0) check("rd_onehot", bus.req_rd, one << arb_gnt_id);
        if (bus.usr_ob_wr) begin
          wr_t.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_wr", bus.usr_ob_tlv, 0);
          end else begin
            e = exp_q.pop_front();
            check("ob_tlv", bus.usr_ob_tlv, e);
          end
        end
        prev_rd = |bus.req_rd;
        rd_cap  = bus.req_rd;
      end
    end
  end

  // Engine FIFO model: pop what the DUT strobed in the previous cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (rd_cap[i] && fq[i].size() != 0) begin
            void'(fq[i].pop_front());
            npop[i]++;
          end
        end
      end
      rd_cap = '0;
      refresh();
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned s1_gap [5] = '{1, 1, 2, 1, 1};
    bus.usr_ob_afull = 1'b0;
    refresh();
    reset_assert();
    reset_release();

    // Engines 0 and 2 each present a 3-word TLV at once.
    @(negedge clk);
    wr_t.delete();
    load(0, 1, 0, 3, 3);
    load(2, 2, 0, 3, 3);
    expect_tlv(0, 1, 0, 3, 3);
    expect_tlv(2, 2, 0, 3, 3);
    wait_idle("s1_drain");
    check("s1_nwr", wr_t.size(), 6);
    if (wr_t.size() == 6)
      for (int i = 0; i < 5; i++) check("s1_gap", wr_t[i+1] - wr_t[i], s1_gap[i]);

    // All four engines non-empty with 1-word TLVs.
    @(negedge clk);
    reset_assert();
    reset_release();
    @(negedge clk);
    wr_t.delete();
    for (int unsigned i = 0; i < N; i++) begin
      load(i, 10 + i, 0, 1, 1);
      load(i, 20 + i, 0, 1, 1);
    end
    for (int unsigned i = 0; i < N; i++) expect_tlv(i, 10 + i, 0, 1, 1);
    for (int unsigned i = 0; i < N; i++) expect_tlv(i, 20 + i, 0, 1, 1);
    wait_idle("s2_drain");
    check("s2_nwr", wr_t.size(), 8);
    if (wr_t.size() == 8)
      for (int i = 0; i < 7; i++) check("s2_gap", wr_t[i+1] - wr_t[i], 2);

    // afull for 5 cycles in the middle of engine 1's 4-word TLV.
    @(negedge clk);
    reset_assert();
    reset_release();
    @(negedge clk);
    load(1, 30, 0, 4, 4);
    expect_tlv(1, 30, 0, 4, 4);
    wait_pops(1, 2, "s3_reach");
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      if (k == 0) bus.usr_ob_afull = 1'b1;
      #1;
      check("s3_rd", bus.req_rd, 0);
      check("s3_gnt", arb_gnt_id, 1);
      check("s3_busy", arb_busy, 1);
      if (k != 0) check("s3_wr", bus.usr_ob_wr, 0);
    end
    check("s3_npop", npop[1], 2);
    @(negedge clk);
    bus.usr_ob_afull = 1'b0;
    wait_idle("s3_drain");

    // Reset mid-TLV of engine 3; engine 0 must win afterwards.
    @(negedge clk);
    reset_assert();
    reset_release();
    @(negedge clk);
    load(3, 40, 0, 4, 4);
    expect_tlv(3, 40, 0, 2, 4);
    wait_pops(3, 2, "s4_reach");
    check("s4_gnt_pre", arb_gnt_id, 3);
    reset_assert();
    load(0, 41, 0, 1, 1);
    load(3, 42, 0, 1, 1);
    expect_tlv(0, 41, 0, 1, 1);
    expect_tlv(3, 42, 0, 1, 1);
    reset_release();
    for (int c = 0; c < 20 && !arb_busy; c++) @(negedge clk);
    check("s4_busy", arb_busy, 1);
    check("s4_first_gnt", arb_gnt_id, 0);
    wait_idle("s4_drain");

    // Granted engine runs dry mid-TLV for 20 cycles.
    @(negedge clk);
    reset_assert();
    reset_release();
    @(negedge clk);
    load(2, 50, 0, 2, 4);
    expect_tlv(2, 50, 0, 4, 4);
    wait_pops(2, 2, "s5_reach");
    repeat (20) @(negedge clk);
    #1;
    check("s5_busy", arb_busy, 1);
    check("s5_gnt", arb_gnt_id, 2);
    check("s5_err_stall", arb_error, EXP_ERR);
    @(negedge clk);
    load(2, 50, 2, 2, 4);
    wait_idle("s5_drain");
    check("s5_err_after", arb_error, EXP_ERR);
    check("s5_idle", arb_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_tlvp_usr_arb.md
CR_TLVP_USR_ARB -- requirements
Module: cr_tlvp_usr_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of user engines sharing the cr_tlvp user output path (2..8).
REQ-002 SHALL have parameter WDOG_CYCLES, default 1024, meaning the mid-TLV stall limit in clocks (used only with CR_TLVP_USR_ARB_WDOG_EN).
REQ-003 SHALL have port clk, input, 1, meaning the single block clock.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port req_empty, input, N_REQ, meaning the per-engine outbound TLV FIFO is empty.
REQ-006 SHALL have port req_tlv, input, N_REQ x tlvp_if_bus_t, meaning the per-engine head-of-FIFO TLV word.
REQ-007 SHALL have port req_rd, output, N_REQ, meaning the per-engine FIFO pop strobe.
REQ-008 SHALL have port usr_ob_afull, input, 1, meaning the cr_tlvp user outbound FIFO is almost full.
REQ-009 SHALL have port usr_ob_wr, output, 1, meaning the write strobe into the cr_tlvp user outbound FIFO.
REQ-010 SHALL have port usr_ob_tlv, output, tlvp_if_bus_t, meaning the word written into the cr_tlvp user outbound FIFO.
REQ-011 SHALL have port arb_gnt_id, output, 3, meaning the index of the currently granted engine.
REQ-012 SHALL have port arb_busy, output, 1, meaning a TLV transfer is in progress.
REQ-013 SHALL have port arb_error, output, 1, meaning a sticky watchdog error flag (tied 0 without the macro).

Function
REQ-014 SHALL implement the FSM states IDLE and BUSY.
REQ-015 SHALL, in IDLE with any req_empty bit low, register the grant to the first non-empty engine searching round-robin from last_gnt+1 (mod N_REQ), update last_gnt to it, and enter BUSY on the next cycle.
REQ-016 SHALL, in BUSY, assert req_rd[gnt] combinationally iff ~req_empty[gnt] & ~usr_ob_afull; all other req_rd bits SHALL be 0, and req_rd SHALL be 0 in IDLE.
REQ-017 SHALL register usr_ob_wr = |req_rd and usr_ob_tlv = req_tlv[gnt] on each pop, giving a fixed 1-cycle latency; usr_ob_afull SHALL be set by cr_tlvp with at least 1 entry of margin.
REQ-018 SHALL, when a popped word has eot=1, return to IDLE on the next cycle, so a TLV is never interleaved with another engine's words and one idle cycle separates consecutive TLVs.
REQ-019 SHALL keep the grant across empty or afull stalls mid-TLV and pop nothing during them.
REQ-020 SHALL let an engine that is alone in requesting be re-granted back-to-back after its one idle cycle.
REQ-021 SHALL drive arb_busy = (state==BUSY) and arb_gnt_id = the registered grant.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-TLV, asynchronously force state=IDLE, usr_ob_wr=0, usr_ob_tlv=0, arb_gnt_id=0, arb_error=0, watchdog counter=0, and last_gnt=N_REQ-1 so that engine 0 wins first.
REQ-023 SHALL NOT emit any word or pop in the first cycle after reset deassertion.

Configuration
REQ-024 SHALL implement CR_TLVP_USR_ARB_WDOG_EN: when defined, a counter SHALL increment each BUSY cycle with req_empty[gnt]=1, clear on any pop, saturate, and set arb_error sticky once it reaches WDOG_CYCLES; the grant SHALL be held regardless.
REQ-025 SHALL, when CR_TLVP_USR_ARB_WDOG_EN is undefined, contain no counter and tie arb_error to 0.

Structure
REQ-026 SHALL take tlvp_if_bus_t (including eot) from cr_structs and add to cr_structs the arbiter state enum (ARB_IDLE, ARB_BUSY) and the constant CR_TLVP_USR_ARB_MAX_REQ=8.
REQ-027 SHALL place the round-robin priority pick in one sub-module, cr_tlvp_rr_pick (N_REQ request bits plus last index in, grant index and valid out, purely combinational).

Verification
REQ-028 SHALL be verified by: after reset, engines 0 and 2 each hold a 3-word TLV simultaneously -> output is 0's 3 words then 1 idle cycle then 2's 3 words, with usr_ob_wr lagging req_rd by 1 cycle.
REQ-029 SHALL be verified by: all 4 engines continuously non-empty with 1-word TLVs -> grant order 0,1,2,3,0,... with exactly one idle cycle between grants.
REQ-030 SHALL be verified by: usr_ob_afull held high for 5 cycles in the middle of engine 1's 4-word TLV -> no pop or write during those cycles, grant stays at 1, and all 4 words arrive in order.
REQ-031 SHALL be verified by: rst_n pulsed low mid-TLV of engine 3 -> all outputs 0 immediately and engine 0 is granted first after release.
REQ-032 SHALL be verified by: with the macro defined and WDOG_CYCLES=16, the granted engine goes empty mid-TLV for 16 cycles -> arb_error rises and stays 1 after the TLV completes; without the macro, arb_error stays 0.
